// File: rtl/bcd_time_counter.sv
// bcd_time_counter
// Keeps wall-clock time of day as BCD HH:MM and advances it by one minute every
// N clock cycles. N is TICKS_PER_MIN, or FAST_TICKS while fast_watch is high.
// A new time can be loaded. An out-of-range load is rejected and flagged.
//
// Ports
//   clk          sole clock; all state updates on the rising edge
//   reset        synchronous, active-high
//   load_time    one-cycle request to load new_time
//   new_time     BCD HH:MM: [15:12] ms_hour, [11:8] ls_hour, [7:4] ms_min, [3:0] ls_min
//   fast_watch   selects FAST_TICKS as the minute period
//   current_time registered BCD HH:MM, same layout as new_time
//   one_minute   registered pulse, high in the cycle the advanced minute is shown
//   load_err     registered pulse on a rejected load
//   time_set     high once a valid time has been loaded since reset
module bcd_time_counter #(
    parameter int TICKS_PER_MIN = 15360,
    parameter int FAST_TICKS    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_time,
    input  logic [15:0] new_time,
    input  logic        fast_watch,
    output logic [15:0] current_time,
    output logic        one_minute,
    output logic        load_err,
    output logic        time_set
);

    localparam int MAX_TICKS = (TICKS_PER_MIN > FAST_TICKS) ? TICKS_PER_MIN : FAST_TICKS;
    localparam int PW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [PW-1:0] NORM_LAST = PW'(TICKS_PER_MIN - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_TICKS - 1);

    typedef enum logic {
        UNSET = 1'b0,
        SET   = 1'b1
    } state_t;

    // A legal HH:MM has hours 00..23 and minutes 00..59.
    function automatic logic bcd_valid(input logic [15:0] t);
        logic hour_ok;
        if (t[15:12] == 4'd2) begin
            hour_ok = (t[11:8] <= 4'd3);
        end else begin
            hour_ok = (t[15:12] <= 4'd1) && (t[11:8] <= 4'd9);
        end
        return hour_ok && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    // Advance a legal BCD HH:MM by one minute. 23:59 wraps to 00:00.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[15:8] == 8'h23) begin
                    r[15:8] = 8'h00;
                end else if (t[11:8] == 4'd9) begin
                    r[11:8]  = 4'd0;
                    r[15:12] = t[15:12] + 4'd1;
                end else begin
                    r[11:8] = t[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    logic [PW-1:0] presc_r, presc_s, last_s;
    logic [15:0]   time_r, time_s;
    logic          pulse_r, pulse_s;
    logic          err_r, err_s;
    logic          fast_r;
    logic          load_ok_s, fw_change_s, tc_s;
    state_t        state_r, state_s;

    // Terminal prescaler value for the minute period currently selected.
    always_comb begin
        if (fast_watch) begin
            last_s = FAST_LAST;
        end else begin
            last_s = NORM_LAST;
        end
    end

    assign load_ok_s   = load_time && bcd_valid(new_time);
    assign fw_change_s = (fast_watch != fast_r);
    // ">=" also catches a count left above a shorter period. A mode change always
    // clears the count, so normally this is an equality test.
    assign tc_s        = (presc_r >= last_s);

    // Next value of time, prescaler and pulses. Priority: valid load, mode change, terminal count.
    always_comb begin
        time_s  = time_r;
        presc_s = presc_r + PW'(1);
        pulse_s = 1'b0;
        err_s   = 1'b0;
        if (load_ok_s) begin
            time_s  = new_time;
            presc_s = '0;
        end else begin
            err_s = load_time;
            if (fw_change_s) begin
                presc_s = '0;
            end else if (tc_s) begin
                presc_s = '0;
                time_s  = bcd_inc(time_r);
                pulse_s = 1'b1;
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end
    end

    // FSM next state: the first valid load sets the clock; only reset unsets it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            UNSET: begin
                if (load_ok_s) begin
                    state_s = SET;
                end else begin
                    state_s = UNSET;
                end
            end
            SET:     state_s = SET;
            default: state_s = UNSET;
        endcase
    end

    // Datapath and state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            time_r  <= 16'h0000;
            presc_r <= '0;
            pulse_r <= 1'b0;
            err_r   <= 1'b0;
            state_r <= UNSET;
        end else begin
            time_r  <= time_s;
            presc_r <= presc_s;
            pulse_r <= pulse_s;
            err_r   <= err_s;
            state_r <= state_s;
        end
    end

    // Previous fast_watch level. It follows the input through reset, so a level
    // held across reset release does not count as a mode change.
    always_ff @(posedge clk) begin
        fast_r <= fast_watch;
    end

    assign current_time = time_r;
    assign one_minute   = pulse_r;
    assign load_err     = err_r;
    assign time_set     = (state_r == SET);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Testbench for bcd_time_counter with short minute periods (normal 6, fast 4).
// A model keeps time as minutes-of-day and converts it to BCD.
// Expected outputs are queued when each cycle's stimulus is applied.
// They are popped and compared just after the clock edge.
module tb_bcd_time_counter;

    localparam int NORM_N = 6;
    localparam int FAST_N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_time = 1'b0;
    logic [15:0] new_time = 16'h0000;
    logic        fast_watch = 1'b0;
    logic [15:0] current_time;
    logic        one_minute;
    logic        load_err;
    logic        time_set;

    bcd_time_counter #(.TICKS_PER_MIN(NORM_N), .FAST_TICKS(FAST_N)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_time    (load_time),
        .new_time     (new_time),
        .fast_watch   (fast_watch),
        .current_time (current_time),
        .one_minute   (one_minute),
        .load_err     (load_err),
        .time_set     (time_set)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t;
        logic        p;
        logic        e;
        logic        s;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state.
    int   m_min   = 0;
    int   m_presc = 0;
    logic m_fw    = 1'b0;
    logic m_set   = 1'b0;
    logic cur_fw  = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int m);
        int h, mm;
        h  = m / 60;
        mm = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    function automatic logic is_legal(input logic [15:0] t);
        int h;
        h = int'(t[15:12]) * 10 + int'(t[11:8]);
        return (t[11:8] <= 4'd9) && (t[3:0] <= 4'd9) && (t[7:4] <= 4'd5) && (h < 24);
    endfunction

    function automatic int to_min(input logic [15:0] t);
        return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    // Apply one cycle of stimulus, queue the model's prediction, then compare after the edge.
    task automatic step(input logic r, input logic ld, input logic [15:0] nt, input logic fw);
        exp_t e;
        exp_t g;
        int   n;
        reset = r; load_time = ld; new_time = nt; fast_watch = fw;
        e.p = 1'b0;
        e.e = 1'b0;
        if (r) begin
            m_min = 0; m_presc = 0; m_set = 1'b0;
        end else begin
            n = fw ? FAST_N : NORM_N;
            if (ld && is_legal(nt)) begin
                m_min = to_min(nt); m_presc = 0; m_set = 1'b1;
            end else begin
                e.e = ld;
                if (fw != m_fw) begin
                    m_presc = 0;
                end else if (m_presc == n - 1) begin
                    m_presc = 0;
                    m_min   = (m_min + 1) % 1440;
                    e.p     = 1'b1;
                end else begin
                    m_presc++;
                end
            end
        end
        m_fw = fw;
        e.t  = to_bcd(m_min);
        e.s  = m_set;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 16'd0, 16'd1);
        end else begin
            g = sb.pop_front();
            check("current_time", current_time, g.t);
            check("one_minute", {15'd0, one_minute}, {15'd0, g.p});
            check("load_err", {15'd0, load_err}, {15'd0, g.e});
            check("time_set", {15'd0, time_set}, {15'd0, g.s});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, cur_fw);
    endtask

    task automatic ld(input logic [15:0] nt);
        step(1'b0, 1'b1, nt, cur_fw);
    endtask

    initial begin
        logic        r, l, f;
        logic [15:0] nt;

        // Reset with fast mode on; minutes at cycles 4 and 8 after release.
        cur_fw = 1'b1;
        step(1'b1, 1'b0, 16'h0000, cur_fw);
        step(1'b1, 1'b0, 16'h0000, cur_fw);
        check("reset_time", current_time, 16'h0000);
        check("reset_set", {15'd0, time_set}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            idle(1);
            check("fast_pulse_pos", {15'd0, one_minute}, (i == 3 || i == 7) ? 16'd1 : 16'd0);
        end
        check("fast_two_minutes", current_time, 16'h0002);

        // BCD rollovers.
        ld(16'h2359); idle(4); check("wrap_2359", current_time, 16'h0000);
        check("wrap_pulse", {15'd0, one_minute}, 16'd1);
        ld(16'h0959); idle(4); check("carry_0959", current_time, 16'h1000);
        ld(16'h1959); idle(4); check("carry_1959", current_time, 16'h2000);

        // Rejected loads from a set state.
        ld(16'h0815);
        ld(16'h2400); check("bad_2400_err", {15'd0, load_err}, 16'd1);
        check("bad_2400_time", current_time, 16'h0815);
        ld(16'h1260); check("bad_1260_err", {15'd0, load_err}, 16'd1);
        check("bad_1260_time", current_time, 16'h0815);
        check("bad_keeps_set", {15'd0, time_set}, 16'd1);

        // Loads landing on the terminal count.
        ld(16'h0815); idle(3);
        ld(16'h0700); check("tc_load_time", current_time, 16'h0700);
        check("tc_load_nopulse", {15'd0, one_minute}, 16'd0);
        idle(3); check("tc_load_wait", {15'd0, one_minute}, 16'd0);
        idle(1); check("tc_load_next", current_time, 16'h0701);
        idle(3);
        ld(16'h0A00); check("tc_bad_time", current_time, 16'h0702);
        check("tc_bad_pulse", {15'd0, one_minute}, 16'd1);
        check("tc_bad_err", {15'd0, load_err}, 16'd1);

        // Mode change mid-minute clears the prescaler.
        ld(16'h1200); idle(2);
        cur_fw = 1'b0; idle(1);
        check("fw_nopulse", {15'd0, one_minute}, 16'd0);
        idle(5); check("fw_wait", current_time, 16'h1200);
        idle(1); check("fw_full_n", current_time, 16'h1201);

        // Reset wins over a coincident valid load.
        step(1'b1, 1'b1, 16'h1130, cur_fw);
        check("rst_load_time", current_time, 16'h0000);
        check("rst_load_set", {15'd0, time_set}, 16'd0);
        check("rst_load_err", {15'd0, load_err}, 16'd0);

        // Held load reloads every cycle.
        for (int i = 0; i < 8; i++) ld(16'h0130);
        idle(NORM_N); check("held_load_then", current_time, 16'h0131);

        // Randomised mix of loads, mode changes and occasional resets.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) nt = to_bcd(int'($urandom_range(0, 1439)));
            else nt = 16'($urandom_range(0, 65535));
            f = cur_fw;
            if ($urandom_range(0, 29) == 0) f = ~cur_fw;
            cur_fw = f;
            step(r, l, nt, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 The module SHALL have parameter TICKS_PER_MIN, default 15360, meaning clk cycles per minute in normal mode.
REQ-002 The module SHALL have parameter FAST_TICKS, default 256, meaning clk cycles per minute in fast-watch mode.
REQ-003 The module SHALL have one clock and a synchronous active-high reset: clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 load_time  input  1  one-cycle request to load new_time.
REQ-006 new_time  input  16  BCD HH:MM as [15:12] ms_hour, [11:8] ls_hour, [7:4] ms_min, [3:0] ls_min.
REQ-007 fast_watch  input  1  selects FAST_TICKS as the minute period.
REQ-008 current_time  output  16  registered BCD HH:MM, same field layout as new_time.
REQ-009 one_minute  output  1  registered one-cycle pulse, high in the cycle current_time shows the newly advanced minute.
REQ-010 load_err  output  1  registered one-cycle pulse on a rejected load.
REQ-011 time_set  output  1  high once a valid time has been loaded since reset.

Function
REQ-012 The prescaler SHALL count 0..N-1, where N = FAST_TICKS if fast_watch else TICKS_PER_MIN; its width SHALL be sized from the larger parameter.
REQ-013 At prescaler == N-1, the prescaler SHALL wrap to 0 and, on the same edge, current_time SHALL advance one minute and one_minute SHALL go high for exactly one cycle.
REQ-014 Minute advance SHALL be BCD: ls_min 9->0 carries to ms_min; ms_min 5->0 carries to hours; ls_hour 9->0 carries to ms_hour (09->10, 19->20); 23:59 SHALL wrap to 00:00.
REQ-015 A change of fast_watch value (registered compare) SHALL clear the prescaler to 0 on that edge, with no one_minute pulse in that cycle.
REQ-016 A load SHALL be valid iff ms_hour<=2, ls_hour<=9, (ms_hour==2 implies ls_hour<=3), ms_min<=5 and ls_min<=9.
REQ-017 On a valid load, the next edge SHALL set current_time = new_time, clear the prescaler to 0, and hold one_minute low that cycle.
REQ-018 On an invalid load, current_time and the prescaler SHALL be unaffected by the load, and load_err SHALL pulse high for one cycle.
REQ-019 For a valid load coincident with terminal count, the load SHALL win: no increment and no one_minute pulse.
REQ-020 For an invalid load coincident with terminal count, the increment and one_minute pulse SHALL proceed normally and load_err SHALL pulse.
REQ-021 A valid load coincident with a fast_watch change SHALL load and clear the prescaler once.
REQ-022 The FSM SHALL have two states: UNSET (time_set=0) and SET (time_set=1).
REQ-023 The FSM SHALL go UNSET->SET on a valid load; SET SHALL persist until reset, and invalid loads SHALL cause no transition.
REQ-024 Time SHALL count in both states.
REQ-025 Holding load_time high for multiple cycles SHALL reload every cycle, keeping the prescaler at 0.

Reset
REQ-026 While reset is high on an edge, the next state SHALL be: current_time=16'h0000, prescaler=0, one_minute=0, load_err=0, time_set=0, FSM=UNSET.
REQ-027 Reset SHALL take priority over load_time, terminal count and a fast_watch change.
REQ-028 Reset asserted mid-minute SHALL discard partial prescaler progress.
REQ-029 Counting SHALL resume on the first edge after reset deasserts, with the first one_minute pulse N edges after reset release.

Verification
REQ-030 Reset, then FAST_TICKS=4 and fast_watch=1 for 8 cycles -> one_minute pulses at cycles 4 and 8; current_time 0000->0001->0002.
REQ-031 Load 16'h2359, then run one minute -> current_time=16'h0000 with a one_minute pulse; load 16'h0959 then run -> 16'h1000; load 16'h1959 then run -> 16'h2000.
REQ-032 Load 16'h2400 and 16'h1260 from a SET state at 16'h0815 -> load_err pulses twice; current_time stays 16'h0815; time_set stays 1.
REQ-033 Valid load of 16'h0700 at prescaler N-1 -> current_time=16'h0700, no one_minute pulse, next pulse N cycles later; the same with invalid 16'h0A00 -> current_time increments and both one_minute and load_err pulse.
REQ-034 Toggle fast_watch at prescaler 2 of 4 -> prescaler clears, no pulse; next pulse after the full new N cycles.
REQ-035 Assert reset during a valid load at 16'h1130 in SET -> current_time=16'h0000, time_set=0, load_err=0.
